// File: rtl/frame_plotter.sv
// Frame plotter: turns one frame of game object state into a one-pixel-per-clock
// write stream for the 160x120 VGA adapter. It erases the previous frame's objects, then draws the new ones.
module frame_plotter #(
   parameter int          SCREEN_W = 160,
   parameter int          SCREEN_H = 120,
   parameter int          DUDE_SZ  = 4,
   parameter int          WALL_W   = 4,
   parameter int          GAP_H    = 32,
   parameter logic [2:0]  C_BG     = 3'b000,
   parameter logic [2:0]  C_DUDE   = 3'b111,
   parameter logic [2:0]  C_WALL   = 3'b010
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic [7:0] dude_x,
   input  logic [6:0] dude_y,
   input  logic [7:0] wall_x,
   input  logic [6:0] gap_y,
   output logic       busy,
   output logic       done,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot
);

   localparam logic [8:0] X_LIM      = 9'(SCREEN_W);
   localparam logic [7:0] Y_LIM      = 8'(SCREEN_H);
   localparam logic [7:0] DUDE_XLAST = 8'(DUDE_SZ - 1);
   localparam logic [6:0] DUDE_YLAST = 7'(DUDE_SZ - 1);
   localparam logic [7:0] WALL_XLAST = 8'(WALL_W - 1);
   localparam logic [6:0] WALL_YLAST = 7'(SCREEN_H - 1);
   localparam logic [7:0] GAP_SPAN   = 8'(GAP_H - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERASE_DUDE,
      S_ERASE_WALL,
      S_DRAW_WALL,
      S_DRAW_DUDE,
      S_DONE
   } state_t;

   state_t     state, state_nx;
   logic [7:0] ox, ox_nx;
   logic [6:0] oy, oy_nx;
   logic       latch;
   logic [7:0] w_last;
   logic [6:0] h_last;

   logic [7:0] cur_dx, cur_wx, prev_dx, prev_wx;
   logic [6:0] cur_dy, cur_gy, prev_dy;
   logic       prev_valid;

   logic [7:0] sel_dx, sel_wx;
   logic [6:0] sel_dy, sel_gy;

   logic [7:0] base_x;
   logic [6:0] base_y;
   logic [2:0] pix_col;
   logic       pix_on;
   logic [8:0] px;
   logic [7:0] py;
   logic [7:0] gap_end;
   logic       in_gap;

   // Rectangle walker: (ox, oy) is the offset of the pixel currently on the outputs.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      state_nx = state;
      ox_nx    = ox;
      oy_nx    = oy;
      latch    = 1'b0;
      w_last   = (state == S_ERASE_DUDE || state == S_DRAW_DUDE) ? DUDE_XLAST : WALL_XLAST;
      h_last   = (state == S_ERASE_DUDE || state == S_DRAW_DUDE) ? DUDE_YLAST : WALL_YLAST;
      case (state)
         S_IDLE: begin
            if (start) begin
               latch    = 1'b1;
               ox_nx    = '0;
               oy_nx    = '0;
               state_nx = prev_valid ? S_ERASE_DUDE : S_DRAW_WALL;
            end
         end
         S_DONE: state_nx = S_IDLE;
         default: begin
            if (ox == w_last) begin
               ox_nx = '0;
               if (oy == h_last) begin
                  oy_nx = '0;
                  case (state)
                     S_ERASE_DUDE: state_nx = S_ERASE_WALL;
                     S_ERASE_WALL: state_nx = S_DRAW_WALL;
                     S_DRAW_WALL:  state_nx = S_DRAW_DUDE;
                     default:      state_nx = S_DONE;
                  endcase
               end else begin
                  oy_nx = oy + 7'd1;
               end
            end else begin
               ox_nx = ox + 8'd1;
            end
         end
      endcase
   end

   // The first pixel is registered on the same edge that accepts start, so the
   // current-frame positions bypass the cur_* registers on that one cycle.
   assign sel_dx = latch ? dude_x : cur_dx;
   assign sel_dy = latch ? dude_y : cur_dy;
   assign sel_wx = latch ? wall_x : cur_wx;
   assign sel_gy = latch ? gap_y  : cur_gy;

   always_comb begin
      base_x  = '0;
      base_y  = '0;
      pix_col = C_BG;
      pix_on  = 1'b0;
      gap_end = {1'b0, sel_gy} + GAP_SPAN;
      in_gap  = ({1'b0, oy_nx} >= {1'b0, sel_gy}) && ({1'b0, oy_nx} <= gap_end);
      case (state_nx)
         S_ERASE_DUDE: begin base_x = prev_dx; base_y = prev_dy; pix_on = 1'b1; end
         S_ERASE_WALL: begin base_x = prev_wx; pix_on = 1'b1; end
         S_DRAW_WALL: begin
            base_x  = sel_wx;
            pix_col = in_gap ? C_BG : C_WALL;
            pix_on  = 1'b1;
         end
         S_DRAW_DUDE: begin
            base_x  = sel_dx;
            base_y  = sel_dy;
            pix_col = C_DUDE;
            pix_on  = 1'b1;
         end
         default: pix_on = 1'b0;
      endcase
      px = {1'b0, base_x} + {1'b0, ox_nx};
      py = {1'b0, base_y} + {1'b0, oy_nx};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= S_IDLE;
         ox         <= '0;
         oy         <= '0;
         cur_dx     <= '0;
         cur_dy     <= '0;
         cur_wx     <= '0;
         cur_gy     <= '0;
         prev_dx    <= '0;
         prev_dy    <= '0;
         prev_wx    <= '0;
         prev_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         x          <= '0;
         y          <= '0;
         colour     <= '0;
         plot       <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state <= state_nx;
         ox    <= ox_nx;
         oy    <= oy_nx;
         if (latch) begin
            cur_dx <= dude_x;
            cur_dy <= dude_y;
            cur_wx <= wall_x;
            cur_gy <= gap_y;
         end
         if (state == S_DONE) begin
            prev_dx    <= cur_dx;
            prev_dy    <= cur_dy;
            prev_wx    <= cur_wx;
            prev_valid <= 1'b1;
         end
         busy   <= (state_nx != S_IDLE);
         done   <= (state_nx == S_DONE);
         plot   <= pix_on && (px < X_LIM) && (py < Y_LIM);
         x      <= pix_on ? px[7:0] : 8'd0;
         y      <= pix_on ? py[6:0] : 7'd0;
         colour <= pix_on ? pix_col : 3'd0;
      end
   end

endmodule

// File: tb/tb_frame_plotter.sv
// Self-checking bench for frame_plotter: a list-of-rectangles reference model
// predicts every pixel of each frame, and the bench compares it with the DUT cycle by cycle.
module tb_frame_plotter;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start;
   logic [7:0] dude_x, wall_x;
   logic [6:0] dude_y, gap_y;
   logic       busy, done, plot;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int x;
      int y;
      int c;
      int p;
   } pix_t;

   pix_t exp_q[$];
   pix_t obs_q[$];

   int m_valid = 0;
   int m_dx, m_dy, m_wx;

   frame_plotter dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .dude_x (dude_x),
      .dude_y (dude_y),
      .wall_x (wall_x),
      .gap_y  (gap_y),
      .busy   (busy),
      .done   (done),
      .x      (x),
      .y      (y),
      .colour (colour),
      .plot   (plot)
   );

   always #5 clk = ~clk;

   // Model: a frame is a list of rectangles painted row-major; out-of-screen pixels are not plotted.
   task automatic add_rect(input int bx, input int by, input int w, input int h,
                           input int c, input int gy, input bit gapped);
      for (int r = 0; r < h; r++) begin
         for (int cc = 0; cc < w; cc++) begin
            pix_t p;
            int ax, ay;
            ax  = bx + cc;
            ay  = by + r;
            p.x = ax % 256;
            p.y = ay % 128;
            p.c = (gapped && r >= gy && r <= gy + 31) ? 0 : c;
            p.p = (ax < 160 && ay < 120) ? 1 : 0;
            exp_q.push_back(p);
         end
      end
   endtask

   task automatic build_expected(input int dx, input int dy, input int wx, input int gy);
      exp_q.delete();
      if (m_valid != 0) begin
         add_rect(m_dx, m_dy, 4, 4, 0, 0, 1'b0);
         add_rect(m_wx, 0, 4, 120, 0, 0, 1'b0);
      end
      add_rect(wx, 0, 4, 120, 2, gy, 1'b1);
      add_rect(dx, dy, 4, 4, 7, 0, 1'b0);
   endtask

   // mode 0: plain frame; 1: start pulse and input changes at pixel 200; 2: reset at pixel 300.
   task automatic do_frame(input int dx, input int dy, input int wx, input int gy,
                           input int mode, input bit hold);
      dude_x = 8'(dx);
      dude_y = 7'(dy);
      wall_x = 8'(wx);
      gap_y  = 7'(gy);
      start  = 1'b1;
      build_expected(dx, dy, wx, gy);
      obs_q.delete();
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      for (int k = 0; k < exp_q.size(); k++) begin
         pix_t o;
         o.x = int'(x);
         o.y = int'(y);
         o.c = int'(colour);
         o.p = int'(plot);
         obs_q.push_back(o);
         checks++;
         if ({x, y, colour, plot, busy, done} !==
             {8'(exp_q[k].x), 7'(exp_q[k].y), 3'(exp_q[k].c), 1'(exp_q[k].p), 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL pixel[%0d]: got x=%0d y=%0d c=%0d plot=%0d busy=%0d done=%0d, want x=%0d y=%0d c=%0d plot=%0d busy=1 done=0",
                     k, x, y, colour, plot, busy, done,
                     exp_q[k].x, exp_q[k].y, exp_q[k].c, exp_q[k].p);
         end
         if (mode == 1 && k == 200) begin
            start  = 1'b1;
            dude_x = 8'($urandom_range(0, 255));
            dude_y = 7'($urandom_range(0, 127));
            wall_x = 8'($urandom_range(0, 255));
            gap_y  = 7'($urandom_range(0, 127));
         end
         if (mode == 1 && k == 201 && !hold) start = 1'b0;
         if (mode == 2 && k == 300) begin
            bit bad;
            resetn = 1'b0;
            @(posedge clk); #1;
            checks++;
            if ({plot, busy, done, x, y, colour} !== 21'd0) begin
               failures++;
               $display("FAIL reset_midframe: got plot=%0d busy=%0d done=%0d x=%0d y=%0d c=%0d, want all 0",
                        plot, busy, done, x, y, colour);
            end
            resetn = 1'b1;
            bad    = 1'b0;
            for (int i = 0; i < 1100; i++) begin
               @(posedge clk); #1;
               if (done !== 1'b0 || busy !== 1'b0 || plot !== 1'b0) bad = 1'b1;
            end
            checks++;
            if (bad) begin
               failures++;
               $display("FAIL quiet_after_reset: got activity (done/busy/plot) after abort, want none");
            end
            m_valid = 0;
            return;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || plot !== 1'b0) begin
         failures++;
         $display("FAIL done_pulse at +%0d: got done=%0d busy=%0d plot=%0d, want done=1 busy=1 plot=0",
                  exp_q.size() + 1, done, busy, plot);
      end
      m_valid = 1;
      m_dx    = dx;
      m_dy    = dy;
      m_wx    = wx;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || plot !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_done: got done=%0d busy=%0d plot=%0d, want 0 0 0", done, busy, plot);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      start  = 1'b0;
      dude_x = 8'($urandom_range(0, 255));
      dude_y = 7'($urandom_range(0, 127));
      wall_x = 8'($urandom_range(0, 255));
      gap_y  = 7'($urandom_range(0, 127));
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, x, y, colour, plot} !== 21'd0) begin
         failures++;
         $display("FAIL reset_state: got busy=%0d done=%0d x=%0d y=%0d c=%0d plot=%0d, want all 0",
                  busy, done, x, y, colour, plot);
      end
      resetn = 1'b1;
      @(posedge clk); #1;
      m_valid = 0;
   endtask

   task automatic test_first_frame();
      bit bad;
      do_frame(10, 50, 100, 40, 0, 1'b0);
      checks++;
      if (obs_q[0].x != 100 || obs_q[0].y != 0 || obs_q[0].c != 2 || obs_q[0].p != 1) begin
         failures++;
         $display("FAIL first_pixel: got (%0d,%0d,c=%0d,p=%0d), want (100,0,c=2,p=1)",
                  obs_q[0].x, obs_q[0].y, obs_q[0].c, obs_q[0].p);
      end
      checks++;
      if (obs_q[495].x != 13 || obs_q[495].y != 53 || obs_q[495].c != 7 || obs_q[495].p != 1) begin
         failures++;
         $display("FAIL last_pixel: got (%0d,%0d,c=%0d,p=%0d), want (13,53,c=7,p=1)",
                  obs_q[495].x, obs_q[495].y, obs_q[495].c, obs_q[495].p);
      end
      bad = 1'b0;
      for (int r = 40; r <= 71; r++)
         if (obs_q[r*4].x != 100 || obs_q[r*4].y != r || obs_q[r*4].c != 0) bad = 1'b1;
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL gap_rows: got a non-background pixel in (100,40..71), want colour 0");
      end
      checks++;
      if (obs_q[39*4].c != 2 || obs_q[72*4].c != 2) begin
         failures++;
         $display("FAIL gap_edges: got c=%0d/%0d at rows 39/72, want 2/2", obs_q[39*4].c, obs_q[72*4].c);
      end
   endtask

   task automatic test_second_frame();
      bit bad;
      do_frame(10, 52, 99, 20, 0, 1'b0);
      bad = 1'b0;
      for (int i = 0; i < 16; i++)
         if (obs_q[i].x != 10 + i % 4 || obs_q[i].y != 50 + i / 4 || obs_q[i].c != 0) bad = 1'b1;
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL erase_dude: got a wrong pixel among the first 16, want box (10..13,50..53) colour 0");
      end
      bad = 1'b0;
      for (int i = 0; i < 480; i++)
         if (obs_q[16+i].x != 100 + i % 4 || obs_q[16+i].y != i / 4 || obs_q[16+i].c != 0) bad = 1'b1;
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL erase_wall: got a wrong pixel in 16..495, want x=100..103 all rows colour 0");
      end
   endtask

   task automatic test_clipping();
      bit bad;
      int plotted_off;
      do_frame(int'($urandom_range(0, 150)), int'($urandom_range(0, 110)), 158, 100, 0, 1'b0);
      plotted_off = 0;
      for (int i = 0; i < obs_q.size(); i++)
         if (obs_q[i].p == 1 && (obs_q[i].x >= 160 || obs_q[i].y >= 120)) plotted_off++;
      checks++;
      if (plotted_off != 0) begin
         failures++;
         $display("FAIL clip_offscreen: got %0d plotted off-screen pixels, want 0", plotted_off);
      end
      bad = 1'b0;
      for (int r = 100; r < 120; r++) begin
         if (obs_q[496 + r*4].c != 0 || obs_q[496 + r*4].p != 1) bad = 1'b1;
         if (obs_q[496 + r*4 + 2].p != 0 || obs_q[496 + r*4 + 3].p != 0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL clip_gap: got wrong colour/plot in gap rows 100..119 at x=158..161, want bg plotted / x>=160 unplotted");
      end
   endtask

   task automatic test_start_ignored();
      do_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 1, 1'b0);
   endtask

   task automatic test_reset_midframe();
      do_frame(int'($urandom_range(0, 159)), int'($urandom_range(0, 119)),
               int'($urandom_range(0, 159)), int'($urandom_range(0, 127)), 2, 1'b0);
      do_frame(int'($urandom_range(0, 159)), int'($urandom_range(0, 119)),
               int'($urandom_range(0, 159)), int'($urandom_range(0, 127)), 0, 1'b0);
   endtask

   task automatic test_random();
      for (int f = 0; f < 4; f++)
         do_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 3; f++)
         do_frame(int'($urandom_range(0, 159)), int'($urandom_range(0, 119)),
                  int'($urandom_range(0, 159)), int'($urandom_range(0, 127)), 0, (f < 2));
      start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_second_frame();
      test_clipping();
      test_start_ignored();
      test_reset_midframe();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/frame_plotter.md
Name: frame_plotter

Overview:
- Consumer end of the game datapath's object-position output: converts one frame of object state (dude box, one wall column with a gap) into a per-pixel write stream for the 160x120 VGA adapter's plot interface.
- On each start it erases the previous frame's objects, then draws the new ones, one pixel per clock.
- The game datapath raises start once per frame tick and waits for done before moving objects again.

Parameters:
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels
- DUDE_SZ, 4, dude box edge length in pixels
- WALL_W, 4, wall column width in pixels
- GAP_H, 32, height of the open gap in the wall
- C_BG, 3'b000, background colour
- C_DUDE, 3'b111, dude colour
- C_WALL, 3'b010, wall colour

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  frame request; sampled only in IDLE
- dude_x  in  8  dude top-left x
- dude_y  in  7  dude top-left y
- wall_x  in  8  wall left x
- gap_y  in  7  first row of the wall gap
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle pulse at end of frame
- x  out  8  pixel x to adapter
- y  out  7  pixel y to adapter
- colour  out  3  pixel colour
- plot  out  1  adapter write enable

Behaviour:
- Reset: clk and resetn as decided, synchronous, active-low. Reset forces all outputs to 0, state to IDLE and prev_valid to 0. It takes effect mid-frame too: the stream is aborted and no done pulse is issued.
- States: IDLE -> ERASE_DUDE -> ERASE_WALL -> DRAW_WALL -> DRAW_DUDE -> DONE -> IDLE.
- IDLE: start=1 at cycle N latches dude_x, dude_y, wall_x and gap_y into cur_* registers.
  - If prev_valid=1, go to ERASE_DUDE.
  - If prev_valid=0 (first frame after reset), go directly to DRAW_WALL.
- Input handling: start while not IDLE is ignored. Inputs are used only via the latched copies; changes after cycle N have no effect on the frame.
- ERASE_DUDE: DUDE_SZ^2 pixels at prev dude box, colour C_BG.
- ERASE_WALL: WALL_W*SCREEN_H pixels, prev wall columns, all rows, colour C_BG.
- DRAW_WALL: WALL_W*SCREEN_H pixels at cur wall. Colour is C_BG when gap_y <= y <= gap_y+GAP_H-1, else C_WALL. Compute the sum 8 bits wide; the gap is clipped at the bottom if it exceeds SCREEN_H-1.
- DRAW_DUDE: DUDE_SZ^2 pixels at cur dude box, colour C_DUDE. The dude is drawn last, so it overwrites the wall.
- Pixel order within every rectangle: row-major, x offset inner, starting at offset (0,0).
- Coordinates: x = base + offset, computed 9 bits wide, y likewise 8 bits wide.
  - Any pixel with x >= SCREEN_W or y >= SCREEN_H has plot=0 but still consumes its cycle.
  - The x/y outputs are truncated.
- Output timing: x, y, colour and plot are registered. Pixel k (0-based, across the whole frame) appears on cycle N+1+k. plot=0 in IDLE and DONE.
- Frame length:
  - P = 2*(DUDE_SZ^2 + WALL_W*SCREEN_H) = 992 with defaults, or 496 when erase is skipped.
  - DONE occupies cycle N+1+P, with done=1 for that single cycle.
  - busy=1 on cycles N+1 .. N+1+P inclusive, 0 otherwise.
- At DONE: cur_* are copied to prev_*, and prev_valid is set to 1.
- Back-to-back frames: start high on the cycle after DONE (back in IDLE) begins a new frame with no extra gap.

Test Plan:
- Reset, then start with dude(10,50), wall(100), gap_y=40:
  - 16+480+480? No: erase skipped, so 496 pixel cycles.
  - First pixel is (100,0,C_WALL) at N+1.
  - Pixels (100,40)..(100,71) are C_BG.
  - Last pixel is (13,53,C_DUDE).
  - done pulses at N+497.
- Second frame, dude(10,52), wall(99):
  - 992 cycles total.
  - First 16 pixels erase box (10..13,50..53) with C_BG.
  - Next 480 pixels erase x=100..103.
  - done at N+993.
- Edge clipping, wall_x=158, gap_y=100:
  - Pixels with x=160,161 have plot=0.
  - Gap rows 100..119 are C_BG, and nothing is plotted beyond y=119.
  - Cycle count is unchanged.
- Assert start at cycle 200 of a frame:
  - It is ignored; the frame finishes on schedule.
  - Latched positions are unchanged even when the inputs are altered mid-frame.
- Assert resetn=0 at cycle 300 of a frame:
  - Next cycle: plot=0, busy=0, done never pulses.
  - The following start draws without erase (496 cycles).
- Hold start high continuously: consecutive frames begin exactly one cycle after each done pulse.
